// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback
// over a shared datapath with variable-latency instruction and data memories.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  S_FETCH  | request instruction; load IR and advance PC on imem_ready
//  S_DECODE | latch opcode; flag illegal opcodes and drop back to fetch
//  S_EXEC   | drive ALU controls from the latched opcode
//  S_MEM    | hold mem_read/mem_write until dmem_ready; stores retire here
//  S_WB     | register file write; R/I/LOAD retire here
//  S_ERR    | memory timeout; bus_error held until reset
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic             mem2reg,
    output logic             alu_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam int         WC_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_ERR
    } state_t;

    state_t            state, state_d;
    logic [6:0]        op_q;
    logic [WC_W-1:0]   wait_cnt;
    logic              is_r, is_i, is_ld, is_st;
    logic              legal_in;
    logic              timed_out;
    logic              retire;
    logic [1:0]        alu_op_sel;

    assign is_r  = (op_q == OP_R);
    assign is_i  = (op_q == OP_I);
    assign is_ld = (op_q == OP_LD);
    assign is_st = (op_q == OP_ST);

    assign legal_in = (opcode == OP_R) || (opcode == OP_I) ||
                      (opcode == OP_LD) || (opcode == OP_ST);

    assign timed_out  = (TIMEOUT != 0) && (wait_cnt == WC_W'(TIMEOUT - 1));
    assign retire     = (state == S_WB) || ((state == S_MEM) && dmem_ready && is_st);
    assign alu_op_sel = is_r ? 2'b10 : (is_i ? 2'b11 : 2'b00);

    always_comb begin
        state_d = state;
        case (state)
            S_FETCH: begin
                if (imem_ready)     state_d = S_DECODE;
                else if (timed_out) state_d = S_ERR;
            end
            S_DECODE: state_d = legal_in ? S_EXEC : S_FETCH;
            S_EXEC:   state_d = (is_ld || is_st) ? S_MEM : S_WB;
            S_MEM: begin
                if (dmem_ready)     state_d = is_ld ? S_WB : S_FETCH;
                else if (timed_out) state_d = S_ERR;
            end
            S_WB:     state_d = S_FETCH;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state <= state_d;
            if (state == S_DECODE) op_q <= opcode;
            // any state change clears the counter, which covers entry to FETCH/MEM
            if (state_d != state)
                wait_cnt <= '0;
            else if ((state == S_FETCH) || (state == S_MEM))
                wait_cnt <= wait_cnt + 1'b1;
            if (retire) instret <= instret + 1'b1;
        end
    end

    always_comb begin
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem2reg       = 1'b0;
        alu_src       = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        alu_op        = 2'b00;
        illegal_instr = 1'b0;
        bus_error     = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            S_DECODE: illegal_instr = !legal_in;
            S_EXEC: begin
                alu_op  = alu_op_sel;
                alu_src = is_i || is_ld || is_st;
            end
            S_MEM: begin
                mem_read  = is_ld;
                mem_write = is_st;
                alu_src   = 1'b1;
            end
            S_WB: begin
                reg_write = 1'b1;
                mem2reg   = is_ld;
                alu_op    = alu_op_sel;
                alu_src   = is_i || is_ld;
            end
            S_ERR:   bus_error = 1'b1;
            default: ;
        endcase
        // the reset state is FETCH, but no strobe may be seen while reset is held
        if (!reset) begin
            imem_req      = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            mem2reg       = 1'b0;
            alu_src       = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            alu_op        = 2'b00;
            illegal_instr = 1'b0;
            bus_error     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: directed instructions push expected
// strobe events; a negedge monitor detects events on the outputs and compares.
module tb_multicycle_sequencer;

    localparam int CW = 4;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [2:0] K_FETCH = 3'd0, K_ILL = 3'd1, K_EXEC = 3'd2,
                           K_MEM = 3'd3, K_WB = 3'd4, K_ERR = 3'd5;

    // {imem_req,ir_write,pc_write,reg_write,mem2reg,alu_src,mem_read,mem_write,alu_op,illegal,bus_error}
    localparam logic [11:0] V_FETCH  = 12'hE00;
    localparam logic [11:0] V_ILL    = 12'h002;
    localparam logic [11:0] V_EXEC_R = 12'h008;
    localparam logic [11:0] V_EXEC_I = 12'h04C;
    localparam logic [11:0] V_EXEC_M = 12'h040;
    localparam logic [11:0] V_WB_R   = 12'h108;
    localparam logic [11:0] V_WB_I   = 12'h14C;
    localparam logic [11:0] V_WB_LD  = 12'h1C0;
    localparam logic [11:0] V_MEM_LD = 12'h060;
    localparam logic [11:0] V_MEM_ST = 12'h050;
    localparam logic [11:0] V_ERR    = 12'h001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [6:0] opcode = '0;
    logic imem_ready = 1'b0;
    logic dmem_ready = 1'b0;
    logic imem_req, ir_write, pc_write, reg_write, mem2reg, alu_src;
    logic mem_read, mem_write, illegal_instr, bus_error;
    logic [1:0] alu_op;
    logic [CW-1:0] instret;
    logic [11:0] sig_now;

    multicycle_sequencer #(.TIMEOUT(16), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .mem2reg(mem2reg), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .instret(instret)
    );

    assign sig_now = {imem_req, ir_write, pc_write, reg_write, mem2reg, alu_src,
                      mem_read, mem_write, alu_op, illegal_instr, bus_error};

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    kind;
        logic [11:0]   sig;
        logic [7:0]    delta;
        logic [7:0]    len;
        logic [CW-1:0] ir;
    } ev_t;

    ev_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;
    logic [CW-1:0] model = '0;

    int   cyc = 0;
    int   fetch_cyc = 0;
    int   memlen = 0;
    logic err_prev = 1'b0;

    always @(negedge clk) begin : mon
        ev_t  got;
        ev_t  want;
        logic hit;
        cyc++;
        hit = 1'b0;
        got = '0;
        if (!reset) begin
            memlen   = 0;
            err_prev = 1'b0;
        end else begin
            if (ir_write) begin
                hit = 1'b1; got.kind = K_FETCH; fetch_cyc = cyc;
            end else if (illegal_instr) begin
                hit = 1'b1; got.kind = K_ILL;
            end else if (reg_write) begin
                hit = 1'b1; got.kind = K_WB;
            end else if (mem_read || mem_write) begin
                memlen++;
                if (dmem_ready) begin
                    hit = 1'b1; got.kind = K_MEM; got.len = 8'(memlen); memlen = 0;
                end
            end else if (alu_src || (alu_op != 2'b00)) begin
                hit = 1'b1; got.kind = K_EXEC;
            end else if (bus_error && !err_prev) begin
                hit = 1'b1; got.kind = K_ERR;
            end
            err_prev = bus_error;
            if (hit) begin
                got.sig   = sig_now;
                got.delta = (got.kind == K_FETCH || got.kind == K_ERR) ? 8'd0 : 8'(cyc - fetch_cyc);
                got.ir    = instret;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got kind=%0d sig=%h at cycle %0d, expected no event",
                             got.kind, got.sig, cyc);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL sb_event: got kind=%0d sig=%h delta=%0d len=%0d instret=%0d, expected kind=%0d sig=%h delta=%0d len=%0d instret=%0d",
                                 got.kind, got.sig, got.delta, got.len, got.ir,
                                 want.kind, want.sig, want.delta, want.len, want.ir);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] k, input logic [11:0] s, input int d, input int l);
        ev_t e;
        e.kind = k; e.sig = s; e.delta = 8'(d); e.len = 8'(l); e.ir = model;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Called with the DUT in FETCH, 1 time unit after a rising edge.
    task automatic do_instr(input logic [6:0] op, input int iw, input int dw);
        logic legal;
        legal = 1'b1;
        push(K_FETCH, V_FETCH, 0, 0);
        case (op)
            OP_R:  begin push(K_EXEC, V_EXEC_R, 2, 0); push(K_WB, V_WB_R, 3, 0); end
            OP_I:  begin push(K_EXEC, V_EXEC_I, 2, 0); push(K_WB, V_WB_I, 3, 0); end
            OP_LD: begin
                push(K_EXEC, V_EXEC_M, 2, 0);
                push(K_MEM, V_MEM_LD, 3 + dw, dw + 1);
                push(K_WB, V_WB_LD, 4 + dw, 0);
            end
            OP_ST: begin
                push(K_EXEC, V_EXEC_M, 2, 0);
                push(K_MEM, V_MEM_ST, 3 + dw, dw + 1);
            end
            default: begin push(K_ILL, V_ILL, 1, 0); legal = 1'b0; end
        endcase
        imem_ready = 1'b0;
        repeat (iw) step();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        opcode = op;
        step();
        if (legal) begin
            step();
            if (op == OP_LD || op == OP_ST) begin
                dmem_ready = 1'b0;
                repeat (dw) step();
                dmem_ready = 1'b1;
                step();
                dmem_ready = 1'b0;
                if (op == OP_LD) step();
            end else begin
                step();
            end
            model = model + 1'b1;
        end
        check("instret_after_instr", 32'(instret), 32'(model));
    endtask

    initial begin
        // reset state
        repeat (2) step();
        check("reset_outputs", 32'(sig_now), 32'h0);
        check("reset_instret", 32'(instret), 32'h0);
        reset = 1'b1;

        do_instr(OP_R, 0, 0);
        check("r_type_instret_1", 32'(instret), 32'h1);
        do_instr(OP_LD, 0, 3);
        do_instr(OP_BAD, 0, 0);
        check("illegal_not_retired", 32'(instret), 32'h2);
        do_instr(OP_ST, 0, 0);
        do_instr(OP_I, 2, 0);
        do_instr(OP_LD, 1, 0);
        do_instr(OP_ST, 0, 2);

        // back-to-back I-type; 4-bit counter wraps through 15 -> 0
        for (int i = 0; i < 16; i++) do_instr(OP_I, 0, 0);
        check("instret_wrapped", 32'(instret), 32'h6);

        // ready on the last allowed fetch cycle wins
        do_instr(OP_R, 15, 0);
        check("no_err_late_ready", 32'(bus_error), 32'h0);

        // fetch timeout
        push(K_ERR, V_ERR, 0, 0);
        imem_ready = 1'b0;
        repeat (15) step();
        check("no_err_before_limit", 32'(bus_error), 32'h0);
        step();
        check("bus_error_set", 32'(bus_error), 32'h1);
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        repeat (5) step();
        check("bus_error_sticky", 32'(bus_error), 32'h1);
        check("err_no_strobes", 32'(sig_now), 32'h001);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("err_cleared_by_reset", 32'(bus_error), 32'h0);
        check("instret_reset", 32'(instret), 32'h0);
        step();
        reset = 1'b1;
        model = '0;

        // STORE aborted by reset while waiting in MEM
        push(K_FETCH, V_FETCH, 0, 0);
        push(K_EXEC, V_EXEC_M, 2, 0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        opcode = OP_ST;
        step();
        step();
        check("store_mem_write_held", 32'(mem_write), 32'h1);
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        check("abort_outputs_zero", 32'(sig_now), 32'h0);
        check("abort_instret_zero", 32'(instret), 32'h0);
        step();
        reset = 1'b1;
        do_instr(OP_R, 0, 0);
        check("restart_instret_1", 32'(instret), 32'h1);

        repeat (3) step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
